// File: rtl/alu_seq.sv
// Registered multi-cycle ALU: one-cycle binary ops, BCD add/subtract one nibble per cycle.
// Handshaked in/out; result and N/Z/C/V/H flags are loaded only on entry to DONE.
module alu_seq #(
   parameter int WIDTH      = 8,
   parameter bit DECIMAL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   input  logic             decimal,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             c_out,
   output logic             v_out,
   output logic             z_out,
   output logic             n_out,
   output logic             hc_out
);
   localparam int NIB = WIDTH / 4;
   localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

   localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR   = 3'd3,
                          OP_EOR = 3'd4, OP_ROR = 3'd5, OP_ROL = 3'd6, OP_PASS = 3'd7;

   typedef enum logic [1:0] {S_IDLE, S_BIN, S_DEC, S_DONE} state_t;

   // Returns {carry, digit} for one BCD nibble step.
   function automatic logic [4:0] bcd_nibble(input logic sub, input logic [3:0] an,
                                             input logic [3:0] bn, input logic cin);
      logic [4:0] t;
      logic [3:0] bx;
      bx = sub ? ~bn : bn;
      t  = {1'b0, an} + {1'b0, bx} + {4'd0, cin};
      if (sub)
         bcd_nibble = t[4] ? {1'b1, t[3:0]} : {1'b0, 4'(t - 5'd6)};
      else
         bcd_nibble = (t > 5'd9) ? {1'b1, 4'(t + 5'd6)} : {1'b0, t[3:0]};
   endfunction

   state_t           r_state, w_next, w_start;
   logic [2:0]       r_op;
   logic [WIDTH-1:0] r_a, r_b;
   logic             r_cin, r_dcar, r_dhc;
   logic [KW-1:0]    r_k;
   logic [WIDTH-5:0] r_acc, w_acc_nx;

   logic             w_accept, w_is_dec;
   logic [WIDTH-1:0] w_bop, w_bin_r, w_dec_r;
   logic [WIDTH:0]   w_sum;
   logic             w_bin_c, w_bin_v, w_bin_hc;
   logic [3:0]       w_an, w_bn;
   logic [4:0]       w_nib;

   assign in_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
   assign out_valid = (r_state == S_DONE);
   assign w_accept  = in_valid & in_ready;
   assign w_is_dec  = DECIMAL_EN & decimal & ((op == OP_ADD) | (op == OP_SUB));
   assign w_start   = w_is_dec ? S_DEC : S_BIN;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_next = w_start;
         S_BIN:  w_next = S_DONE;
         S_DEC:  if (r_k == K_LAST) w_next = S_DONE;
         S_DONE: if (out_ready) w_next = w_accept ? w_start : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Binary path; its V also serves as the decimal V since operands are held unchanged.
   always_comb begin
      w_bop    = (r_op == OP_SUB) ? ~r_b : r_b;
      w_sum    = {1'b0, r_a} + {1'b0, w_bop} + {{WIDTH{1'b0}}, r_cin};
      w_bin_r  = w_sum[WIDTH-1:0];
      w_bin_c  = w_sum[WIDTH];
      w_bin_v  = (r_a[WIDTH-1] == w_bop[WIDTH-1]) & (w_sum[WIDTH-1] != r_a[WIDTH-1]);
      w_bin_hc = r_a[4] ^ w_bop[4] ^ w_sum[4];
      case (r_op)
         OP_AND:  begin w_bin_r = r_a & r_b; w_bin_c = r_cin; w_bin_v = 1'b0; w_bin_hc = 1'b0; end
         OP_OR:   begin w_bin_r = r_a | r_b; w_bin_c = r_cin; w_bin_v = 1'b0; w_bin_hc = 1'b0; end
         OP_EOR:  begin w_bin_r = r_a ^ r_b; w_bin_c = r_cin; w_bin_v = 1'b0; w_bin_hc = 1'b0; end
         OP_ROR:  begin
            w_bin_r = {r_cin, r_a[WIDTH-1:1]}; w_bin_c = r_a[0]; w_bin_v = 1'b0; w_bin_hc = 1'b0;
         end
         OP_ROL:  begin
            w_bin_r = {r_a[WIDTH-2:0], r_cin}; w_bin_c = r_a[WIDTH-1]; w_bin_v = 1'b0; w_bin_hc = 1'b0;
         end
         OP_PASS: begin w_bin_r = r_a; w_bin_c = r_cin; w_bin_v = 1'b0; w_bin_hc = 1'b0; end
         default: ;
      endcase
   end

   // Decimal digits accumulate from the top of r_acc downward; the last digit joins on DONE entry.
   assign w_an    = 4'(r_a >> {r_k, 2'b00});
   assign w_bn    = 4'(r_b >> {r_k, 2'b00});
   assign w_nib   = bcd_nibble(r_op == OP_SUB, w_an, w_bn, r_dcar);
   assign w_dec_r = {w_nib[3:0], r_acc};

   generate
      if (NIB == 2) begin : g_acc2
         assign w_acc_nx = w_nib[3:0];
      end else begin : g_accn
         assign w_acc_nx = {w_nib[3:0], r_acc[WIDTH-5:4]};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_op    <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_cin   <= 1'b0;
         r_dcar  <= 1'b0;
         r_dhc   <= 1'b0;
         r_k     <= '0;
         r_acc   <= '0;
         result  <= '0;
         c_out   <= 1'b0;
         v_out   <= 1'b0;
         z_out   <= 1'b0;
         n_out   <= 1'b0;
         hc_out  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_op   <= op;
            r_a    <= a;
            r_b    <= b;
            r_cin  <= carry_in;
            r_dcar <= carry_in;
            r_k    <= '0;
         end
         if (r_state == S_BIN) begin
            result <= w_bin_r;
            c_out  <= w_bin_c;
            v_out  <= w_bin_v;
            hc_out <= w_bin_hc;
            z_out  <= (w_bin_r == '0);
            n_out  <= w_bin_r[WIDTH-1];
         end
         if (r_state == S_DEC) begin
            r_acc  <= w_acc_nx;
            r_dcar <= w_nib[4];
            r_k    <= r_k + KW'(1);
            if (r_k == '0) r_dhc <= w_nib[4];
            if (r_k == K_LAST) begin
               result <= w_dec_r;
               c_out  <= w_nib[4];
               v_out  <= w_bin_v;
               hc_out <= r_dhc;
               z_out  <= (w_dec_r == '0);
               n_out  <= w_dec_r[WIDTH-1];
            end
         end
      end
   end
endmodule
